// File: rtl/jamma_pkg.sv
// Shared constants for the JAMMA harness input conditioning path.
package jamma_pkg;

    localparam int JAMMA_WIDTH = 29;
    localparam int COIN_A_BIT  = 20;
    localparam int COIN_B_BIT  = 21;

    localparam logic [JAMMA_WIDTH-1:0] COIN_MASK_DEFAULT =
        (JAMMA_WIDTH'(1) << COIN_A_BIT) | (JAMMA_WIDTH'(1) << COIN_B_BIT);

    // JAMMA inputs are active-low, so the released level is 1.
    localparam logic IDLE_LEVEL_DEFAULT = 1'b1;

    // Width of a counter that must hold values 0..maxVal (never narrower than 1 bit).
    function automatic int ctrWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/jamma_debounce_bit.sv
// One harness input: synchroniser chain, tick-paced debounce counter and
// the accepted (stable) level.
module jamma_debounce_bit
    import jamma_pkg::*;
#(
    parameter int   SYNC_STAGES  = 2,
    parameter int   STABLE_TICKS = 4,
    parameter logic IDLE_LEVEL   = IDLE_LEVEL_DEFAULT
) (
    input  logic clk,
    input  logic nReset,
    input  logic tick,
    input  logic din,
    output logic dout
);

    localparam int CW = ctrWidth(STABLE_TICKS);

    logic [SYNC_STAGES-1:0] syncReg;
    logic [CW-1:0]          countReg;
    logic                   stableReg;
    logic                   sampled;

    assign sampled = syncReg[SYNC_STAGES-1];
    assign dout    = stableReg;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            syncReg   <= {SYNC_STAGES{IDLE_LEVEL}};
            countReg  <= '0;
            stableReg <= IDLE_LEVEL;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], din};
            if (tick) begin
                // Any agreeing tick restarts the run, so only consecutive
                // disagreements can ever reach the accept point.
                if (sampled == stableReg) begin
                    countReg <= '0;
                end else if (countReg == CW'(STABLE_TICKS - 1)) begin
                    stableReg <= sampled;
                    countReg  <= '0;
                end else begin
                    countReg <= countReg + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/jamma_input_filter.sv
// Conditions raw JAMMA inputs: per-bit sync + debounce, coin pulse stretching,
// and an output freeze so a packet read sees one consistent snapshot.
module jamma_input_filter
    import jamma_pkg::*;
#(
    parameter int               WIDTH        = JAMMA_WIDTH,
    parameter int               PRESCALE     = 1000,
    parameter int               STABLE_TICKS = 4,
    parameter int               SYNC_STAGES  = 2,
    parameter logic             IDLE_LEVEL   = IDLE_LEVEL_DEFAULT,
    parameter logic [WIDTH-1:0] COIN_MASK    = WIDTH'(COIN_MASK_DEFAULT),
    parameter int               HOLD_TICKS   = 8
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic [WIDTH-1:0] Pin,
    input  logic             freeze,
    output logic [WIDTH-1:0] P,
    output logic             tick
);

    localparam int PW = ctrWidth(PRESCALE - 1);
    localparam int HW = ctrWidth(HOLD_TICKS);

    logic [PW-1:0]          preReg;
    logic [PW-1:0]          preNext;
    logic                   tickReg;
    logic [SYNC_STAGES-1:0] fzSyncReg;
    logic                   fz;
    logic                   fzPrevReg;
    logic [WIDTH-1:0]       stable;
    logic [WIDTH-1:0]       filt;
    logic [WIDTH-1:0]       snapReg;
    logic [WIDTH-1:0]       pReg;

    assign fz   = fzSyncReg[SYNC_STAGES-1];
    assign P    = pReg;
    assign tick = tickReg;

    always_comb begin
        preNext = (preReg == PW'(PRESCALE - 1)) ? '0 : preReg + 1'b1;
    end

    // tick is registered so it is high exactly while the count sits at PRESCALE-1.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            preReg  <= '0;
            tickReg <= 1'b0;
        end else begin
            preReg  <= preNext;
            tickReg <= (preNext == PW'(PRESCALE - 1));
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            jamma_debounce_bit #(
                .SYNC_STAGES (SYNC_STAGES),
                .STABLE_TICKS(STABLE_TICKS),
                .IDLE_LEVEL  (IDLE_LEVEL)
            ) u_deb (
                .clk   (clk),
                .nReset(nReset),
                .tick  (tickReg),
                .din   (Pin[gi]),
                .dout  (stable[gi])
            );

            if (COIN_MASK[gi]) begin : g_coin
                logic [HW-1:0] holdReg;
                logic          actPrevReg;
                logic          act;

                assign act = (stable[gi] != IDLE_LEVEL);

                // Activation is seen one cycle after the accepting tick; when that
                // cycle is itself a tick, the reload absorbs that tick's decrement.
                always_ff @(posedge clk or negedge nReset) begin
                    if (!nReset) begin
                        holdReg    <= '0;
                        actPrevReg <= 1'b0;
                    end else begin
                        actPrevReg <= act;
                        if (act && !actPrevReg) begin
                            holdReg <= (tickReg && !fz) ? HW'(HOLD_TICKS - 1) : HW'(HOLD_TICKS);
                        end else if (tickReg && !fz && (holdReg != '0)) begin
                            holdReg <= holdReg - 1'b1;
                        end
                    end
                end

                assign filt[gi] = (act || (holdReg != '0)) ? ~IDLE_LEVEL : IDLE_LEVEL;
            end else begin : g_plain
                assign filt[gi] = stable[gi];
            end
        end
    endgenerate

    // On the first frozen cycle the snapshot is being taken from filt, so P
    // takes filt directly; from then on it replays the snapshot.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            fzSyncReg <= '0;
            fzPrevReg <= 1'b0;
            snapReg   <= {WIDTH{IDLE_LEVEL}};
            pReg      <= {WIDTH{IDLE_LEVEL}};
        end else begin
            fzSyncReg <= {fzSyncReg[SYNC_STAGES-2:0], freeze};
            fzPrevReg <= fz;
            if (fz && !fzPrevReg) begin
                snapReg <= filt;
            end
            pReg <= (fz && fzPrevReg) ? snapReg : filt;
        end
    end

endmodule

// File: tb/tb_jamma_input_filter.sv
// Bench for jamma_input_filter: table-driven pulse vectors, hand-written
// freeze/latency sequences and a randomized run against a per-cycle model.
module tb_jamma_input_filter;
    import jamma_pkg::*;

    localparam int           W    = JAMMA_WIDTH;
    localparam int           PRE  = 4;
    localparam int           ST   = 4;
    localparam int           SS   = 2;
    localparam int           HT   = 8;
    localparam logic [W-1:0] COIN = 29'h0300000;
    localparam logic         IDLE = 1'b1;

    logic         clk = 1'b0;
    logic         nReset;
    logic         freeze;
    logic [W-1:0] Pin;
    logic [W-1:0] P;
    logic         tick;

    always #5 clk = ~clk;

    jamma_input_filter #(
        .WIDTH       (W),
        .PRESCALE    (PRE),
        .STABLE_TICKS(ST),
        .SYNC_STAGES (SS),
        .IDLE_LEVEL  (IDLE),
        .COIN_MASK   (COIN),
        .HOLD_TICKS  (HT)
    ) dut (
        .clk   (clk),
        .nReset(nReset),
        .Pin   (Pin),
        .freeze(freeze),
        .P     (P),
        .tick  (tick)
    );

    int vecCount  = 0;
    int missCount = 0;

    // Reference model state, advanced once per rising clock edge.
    logic [W-1:0] mSyncQ [SS];
    logic [SS-1:0] mFzQ;
    logic         mFzPrev;
    logic [W-1:0] mStable;
    logic [W-1:0] mSnap;
    logic [W-1:0] mP;
    int           mRun  [W];
    int           mHold [W];
    int           mCycle;

    typedef struct {
        int bitIdx;
        int lowLen;
        int highLen;
        int reps;
        int expLow;
    } pulseVecT;

    pulseVecT vecs [9];

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < SS; k++) mSyncQ[k] = {W{IDLE}};
        mFzQ    = '0;
        mFzPrev = 1'b0;
        mStable = {W{IDLE}};
        mSnap   = {W{IDLE}};
        mP      = {W{IDLE}};
        mCycle  = 0;
        for (int i = 0; i < W; i++) begin
            mRun[i]  = 0;
            mHold[i] = 0;
        end
    endtask

    task automatic modelStep();
        logic [W-1:0] s;
        logic [W-1:0] filt;
        logic         fz;
        logic         tk;
        logic         became;
        if (!nReset) begin
            modelReset();
            return;
        end
        tk = ((mCycle % PRE) == PRE - 1);
        s  = mSyncQ[SS-1];
        fz = mFzQ[SS-1];
        for (int i = 0; i < W; i++) begin
            if (COIN[i]) filt[i] = ((mStable[i] != IDLE) || (mHold[i] > 0)) ? ~IDLE : IDLE;
            else         filt[i] = mStable[i];
        end
        if (fz && !mFzPrev) mSnap = filt;
        mP = fz ? mSnap : filt;
        if (tk) begin
            for (int i = 0; i < W; i++) begin
                became = 1'b0;
                if (s[i] == mStable[i]) begin
                    mRun[i] = 0;
                end else if (mRun[i] == ST - 1) begin
                    mStable[i] = s[i];
                    mRun[i]    = 0;
                    became     = (s[i] != IDLE);
                end else begin
                    mRun[i]++;
                end
                if (COIN[i]) begin
                    if (became)                      mHold[i] = HT;
                    else if (mHold[i] > 0 && !fz)    mHold[i]--;
                end
            end
        end
        for (int k = SS - 1; k > 0; k--) mSyncQ[k] = mSyncQ[k-1];
        mSyncQ[0] = Pin;
        mFzQ      = {mFzQ[SS-2:0], freeze};
        mFzPrev   = fz;
        mCycle++;
    endtask

    task automatic step();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        chk("P_vs_model", 32'(P), 32'(mP));
        chk("tick_vs_model", 32'(tick), 32'((mCycle % PRE) == PRE - 1));
    endtask

    initial begin
        logic [W-1:0] held;
        logic [W-1:0] mask;
        int           lowCount;
        int           othersBad;
        int           lat;
        int           idx;

        vecs[0] = '{7,  10, 0,  1,  0};   // short glitch
        vecs[1] = '{7,  12, 12, 20, 0};   // repeated 3-tick bounces
        vecs[2] = '{5,  16, 0,  1,  16};  // exactly 4 ticks, plain bit
        vecs[3] = '{12, 24, 0,  1,  24};
        vecs[4] = '{20, 16, 0,  1,  32};  // coin stretched to 8 ticks
        vecs[5] = '{20, 40, 0,  1,  40};  // coin longer than hold
        vecs[6] = '{21, 20, 0,  1,  32};
        vecs[7] = '{20, 16, 16, 2,  64};  // retrigger during hold
        vecs[8] = '{21, 36, 0,  1,  36};

        // Reset with random inputs.
        modelReset();
        nReset = 1'b0;
        freeze = 1'b0;
        Pin    = W'($urandom());
        repeat (5) begin
            step();
            chk("reset_P", 32'(P), 32'(29'h1FFFFFFF));
            chk("reset_tick", 32'(tick), 32'(0));
        end
        Pin    = {W{1'b1}};
        nReset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("tick_after_release", 32'(tick), 32'((k % 4) == 3));
        end
        repeat (20) step();

        // Table-driven pulse vectors.
        for (int e = 0; e < 9; e++) begin
            mask = '0;
            mask[vecs[e].bitIdx] = 1'b1;
            lowCount  = 0;
            othersBad = 0;
            for (int r = 0; r < vecs[e].reps; r++) begin
                Pin[vecs[e].bitIdx] = 1'b0;
                repeat (vecs[e].lowLen) begin
                    step();
                    if (P[vecs[e].bitIdx] == 1'b0) lowCount++;
                    if ((P | mask) != {W{1'b1}}) othersBad++;
                end
                Pin[vecs[e].bitIdx] = 1'b1;
                repeat (vecs[e].highLen) begin
                    step();
                    if (P[vecs[e].bitIdx] == 1'b0) lowCount++;
                    if ((P | mask) != {W{1'b1}}) othersBad++;
                end
            end
            repeat (100) begin
                step();
                if (P[vecs[e].bitIdx] == 1'b0) lowCount++;
                if ((P | mask) != {W{1'b1}}) othersBad++;
            end
            chk($sformatf("vec%0d_low_cycles", e), 32'(lowCount), 32'(vecs[e].expLow));
            chk($sformatf("vec%0d_other_bits", e), 32'(othersBad), 32'(0));
        end

        // Clean edge latency on Pin[3].
        Pin[3] = 1'b0;
        lat    = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (lat == 0 && P[3] == 1'b0) lat = k;
        end
        chk("edge_latency_15_to_19", 32'(lat >= 15 && lat <= 19), 32'(1));
        chk("edge_other_bits", 32'(P), 32'(29'h1FFFFFF7));
        Pin[3] = 1'b1;
        repeat (40) step();

        // Freeze snapshot: P must not move while frozen.
        freeze = 1'b1;
        repeat (4) step();
        held      = P;
        othersBad = 0;
        Pin[0]    = 1'b0;
        Pin[10]   = 1'b0;
        repeat (40) begin
            step();
            if (P != held) othersBad++;
        end
        chk("freeze_P_changes", 32'(othersBad), 32'(0));
        freeze = 1'b0;
        repeat (SS + 1) step();
        chk("unfreeze_P0", 32'(P[0]), 32'(0));
        chk("unfreeze_P10", 32'(P[10]), 32'(0));
        Pin[0]  = 1'b1;
        Pin[10] = 1'b1;
        repeat (40) step();

        // Coin pulse entirely inside a freeze window.
        freeze = 1'b1;
        repeat (4) step();
        Pin[21]   = 1'b0;
        othersBad = 0;
        repeat (20) begin
            step();
            if (P[21] != 1'b1) othersBad++;
        end
        Pin[21] = 1'b1;
        repeat (40) begin
            step();
            if (P[21] != 1'b1) othersBad++;
        end
        chk("coin_hidden_while_frozen", 32'(othersBad), 32'(0));
        freeze   = 1'b0;
        lowCount = 0;
        repeat (60) begin
            step();
            if (P[21] == 1'b0) lowCount++;
        end
        chk("coin_after_unfreeze_29_to_32", 32'(lowCount >= 29 && lowCount <= 32), 32'(1));

        // Randomized run against the model, with a mid-run reset.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(7) == 0) begin
                idx = ($urandom_range(3) == 0) ? (20 + int'($urandom_range(1))) : int'($urandom_range(W - 1));
                Pin[idx] = ~Pin[idx];
            end
            if ($urandom_range(99) == 0) freeze = ~freeze;
            if (n == 2000) nReset = 1'b0;
            if (n == 2003) nReset = 1'b1;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
